// File: rtl/data_mem_ctrl.sv
// Byte-addressable 32-bit data memory controller: byte/half/word loads and stores, little-endian.
// Latency: stores commit at the accepting edge; loads return RD_LATENCY cycles after acceptance.
// Backpressure: ready drops while a load is in flight (RD_LATENCY > 1); req without ready is ignored.
//
// Ports:
//   clk, rst         clock, async active-low reset
//   req, we          request strobe, 1 = store / 0 = load
//   size, sign_ext   00 byte, 01 half, 10 word, 11 reserved; load extension mode
//   addr, wr_data    byte address, right-aligned store data
//   ready            request can be accepted this cycle
//   rd_valid/rd_data load result (1-cycle pulse / held between pulses)
//   fault            access error pulse (store: cycle after accept; load: with rd_valid)
module data_mem_ctrl #(
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_SIZE  = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [31:0]          wr_data,
  output logic                 ready,
  output logic                 rd_valid,
  output logic [31:0]          rd_data,
  output logic                 fault
);

  localparam int         IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(RD_LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        ld_fault_q, ld_fault_d;
  logic        rd_valid_q, rd_valid_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        fault_q, fault_d;

  // Memory array is deliberately not reset.
  logic [31:0] mem_q [MEM_DEPTH];

  logic [IDX_W-1:0] idx;
  logic             acc_fault;
  logic             mem_we;
  logic [3:0]       st_be;
  logic [31:0]      st_data;
  logic [31:0]      rd_word;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_ext;

  assign idx     = addr[IDX_W+1:2];
  assign rd_word = mem_q[idx];

  // Any address bit at or above log2(4*MEM_DEPTH) puts the access outside the array.
  always_comb begin
    acc_fault = 1'b0;
    if (size == 2'b11)                          acc_fault = 1'b1;
    if (size == 2'b01 && addr[0])               acc_fault = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00)    acc_fault = 1'b1;
    if ((addr >> (IDX_W + 2)) != '0)            acc_fault = 1'b1;
  end

  // Store lane strobes; data is replicated so every lane sees its own copy.
  always_comb begin
    st_be   = 4'b0000;
    st_data = wr_data;
    case (size)
      2'b00: begin
        st_data = {4{wr_data[7:0]}};
        case (addr[1:0])
          2'd0:    st_be = 4'b0001;
          2'd1:    st_be = 4'b0010;
          2'd2:    st_be = 4'b0100;
          default: st_be = 4'b1000;
        endcase
      end
      2'b01: begin
        st_data = {2{wr_data[15:0]}};
        st_be   = addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10:   st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  // Load lane extraction and extension; word loads ignore sign_ext.
  always_comb begin
    case (addr[1:0])
      2'd0:    ld_byte = rd_word[7:0];
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (size)
      2'b00:   ld_ext = {{24{sign_ext & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{sign_ext & ld_half[15]}}, ld_half};
      default: ld_ext = rd_word;
    endcase
  end

  // Next-state and output logic. The load result is captured at the accepting
  // edge so a later store cannot disturb a load already in flight.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ld_data_d  = ld_data_q;
    ld_fault_d = ld_fault_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    fault_d    = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (we) begin
            if (acc_fault) fault_d = 1'b1;
            else           mem_we  = 1'b1;
          end else if (RD_LATENCY == 1) begin
            rd_valid_d = 1'b1;
            rd_data_d  = acc_fault ? 32'h0 : ld_ext;
            fault_d    = acc_fault;
          end else begin
            state_d    = BUSY;
            cnt_d      = LAT_M1;
            ld_data_d  = acc_fault ? 32'h0 : ld_ext;
            ld_fault_d = acc_fault;
          end
        end
      end
      BUSY: begin
        if (cnt_q <= 4'd1) begin
          state_d    = IDLE;
          cnt_d      = 4'd0;
          rd_valid_d = 1'b1;
          rd_data_d  = ld_data_q;
          fault_d    = ld_fault_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      ld_data_q  <= 32'h0;
      ld_fault_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'h0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ld_data_q  <= ld_data_d;
      ld_fault_q <= ld_fault_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      fault_q    <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (st_be[k]) mem_q[idx][8*k +: 8] <= st_data[8*k +: 8];
      end
    end
  end

  assign ready    = (state_q == IDLE);
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign fault    = fault_q;

endmodule
